// File: rtl/bp_stream_io_cmd_arbiter_pkg.sv
// Shared types and helpers for the two-port BedRock IO command arbiter.
`default_nettype none

package bp_stream_io_cmd_arbiter_pkg;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_data = 1'b1
  } arb_state_e;

  // Round-robin pick between two ports: the priority port wins when it requests.
  function automatic logic rr_pick(input logic [1:0] eligible, input logic prio);
    if (eligible[prio]) return prio;
    else if (eligible[~prio]) return ~prio;
    else return prio;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_stream_io_cmd_arbiter_fifo.sv
// Small 1R1W FIFO holding the issuing-port ID of each command in flight.
`default_nettype none

module bp_stream_io_cmd_arbiter_fifo #(
  parameter int width_p = 1,
  parameter int els_p   = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w-1:0]   wptr_r, rptr_r;
  logic [cnt_w-1:0]   count_r;
  logic               push, pop;

  function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (count_r != cnt_w'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & v_o;
  assign count_o = count_r;

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= bump(wptr_r);
      if (pop)  rptr_r <= bump(rptr_r);
      count_r <= count_r + cnt_w'(push) - cnt_w'(pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bp_stream_io_cmd_arbiter.sv
// Shares one BedRock IO cmd/resp port between the NBF loader (port 0) and the
// host bridge (port 1); round-robin per message, responses returned in order.
`default_nettype none

module bp_stream_io_cmd_arbiter
  import bp_stream_io_cmd_arbiter_pkg::*;
#(
  parameter int hdr_width_p   = 80,
  parameter int data_width_p  = 64,
  parameter int max_credits_p = 16
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,

  input  logic [2*hdr_width_p-1:0]           req_hdr_i,
  input  logic [1:0]                         req_hdr_v_i,
  output logic [1:0]                         req_hdr_ready_and_o,
  input  logic [1:0]                         req_has_data_i,
  input  logic [2*data_width_p-1:0]          req_data_i,
  input  logic [1:0]                         req_data_v_i,
  output logic [1:0]                         req_data_ready_and_o,
  input  logic [1:0]                         req_last_i,

  output logic [hdr_width_p-1:0]             io_cmd_header_o,
  output logic                               io_cmd_header_v_o,
  input  logic                               io_cmd_header_ready_and_i,
  output logic                               io_cmd_has_data_o,
  output logic [data_width_p-1:0]            io_cmd_data_o,
  output logic                               io_cmd_data_v_o,
  input  logic                               io_cmd_data_ready_and_i,
  output logic                               io_cmd_last_o,

  input  logic [hdr_width_p-1:0]             io_resp_header_i,
  input  logic                               io_resp_header_v_i,
  output logic                               io_resp_header_ready_and_o,
  input  logic                               io_resp_has_data_i,
  input  logic [data_width_p-1:0]            io_resp_data_i,
  input  logic                               io_resp_data_v_i,
  output logic                               io_resp_data_ready_and_o,
  input  logic                               io_resp_last_i,

  output logic [2*hdr_width_p-1:0]           req_resp_header_o,
  output logic [1:0]                         req_resp_header_v_o,
  input  logic [1:0]                         req_resp_header_ready_and_i,
  output logic [1:0]                         req_resp_has_data_o,
  output logic [2*data_width_p-1:0]          req_resp_data_o,
  output logic [1:0]                         req_resp_data_v_o,
  input  logic [1:0]                         req_resp_data_ready_and_i,
  output logic [1:0]                         req_resp_last_o,

  output logic [$clog2(max_credits_p+1)-1:0] outstanding_o
);

  arb_state_e state_r, state_n;
  logic       grant_r, rr_r;
  logic [1:0] eligible;
  logic       winner, hdr_hs, data_hs;
  logic       fifo_ready, fifo_v, fifo_head, fifo_yumi;

  // Gating with reset_n_i keeps header valid/ready low while reset is held.
  assign eligible = req_hdr_v_i & {2{fifo_ready & reset_n_i}};
  assign winner   = rr_pick(eligible, rr_r);

  always_comb begin
    state_n              = state_r;
    io_cmd_header_o      = winner ? req_hdr_i[2*hdr_width_p-1:hdr_width_p]
                                  : req_hdr_i[hdr_width_p-1:0];
    io_cmd_has_data_o    = req_has_data_i[winner];
    io_cmd_data_o        = grant_r ? req_data_i[2*data_width_p-1:data_width_p]
                                   : req_data_i[data_width_p-1:0];
    io_cmd_header_v_o    = 1'b0;
    io_cmd_data_v_o      = 1'b0;
    io_cmd_last_o        = 1'b0;
    req_hdr_ready_and_o  = '0;
    req_data_ready_and_o = '0;
    hdr_hs               = 1'b0;
    data_hs              = 1'b0;
    case (state_r)
      e_idle: begin
        io_cmd_header_v_o           = |eligible;
        req_hdr_ready_and_o[winner] = io_cmd_header_ready_and_i & (|eligible);
        hdr_hs = io_cmd_header_v_o & io_cmd_header_ready_and_i;
        if (hdr_hs && req_has_data_i[winner]) state_n = e_data;
      end
      e_data: begin
        io_cmd_data_v_o                = req_data_v_i[grant_r];
        io_cmd_last_o                  = req_last_i[grant_r];
        req_data_ready_and_o[grant_r]  = io_cmd_data_ready_and_i;
        data_hs = io_cmd_data_v_o & io_cmd_data_ready_and_i;
        if (data_hs && io_cmd_last_o) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      grant_r <= 1'b0;
      rr_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      if (hdr_hs) begin
        rr_r <= ~winner;
        if (req_has_data_i[winner]) grant_r <= winner;
      end
    end
  end

  // Responses follow the head ID; with no command in flight they stall.
  always_comb begin
    req_resp_header_o          = {2{io_resp_header_i}};
    req_resp_has_data_o        = {2{io_resp_has_data_i}};
    req_resp_data_o            = {2{io_resp_data_i}};
    req_resp_header_v_o        = '0;
    req_resp_data_v_o          = '0;
    req_resp_last_o            = '0;
    io_resp_header_ready_and_o = fifo_v & req_resp_header_ready_and_i[fifo_head];
    io_resp_data_ready_and_o   = fifo_v & req_resp_data_ready_and_i[fifo_head];
    if (fifo_v) begin
      req_resp_header_v_o[fifo_head] = io_resp_header_v_i;
      req_resp_data_v_o[fifo_head]   = io_resp_data_v_i;
      req_resp_last_o[fifo_head]     = io_resp_last_i;
    end
    fifo_yumi = (io_resp_header_v_i & io_resp_header_ready_and_o & ~io_resp_has_data_i)
              | (io_resp_data_v_i & io_resp_data_ready_and_o & io_resp_last_i);
  end

  bp_stream_io_cmd_arbiter_fifo #(
    .width_p (1),
    .els_p   (max_credits_p)
  ) id_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (hdr_hs),
    .data_i    (winner),
    .ready_o   (fifo_ready),
    .v_o       (fifo_v),
    .data_o    (fifo_head),
    .yumi_i    (fifo_yumi),
    .count_o   (outstanding_o)
  );

endmodule

`default_nettype wire
